// File: rtl/alu_rs_scheduler_if.sv
// alu_rs_scheduler_if: decoder dispatch, CDB snoop and ALU issue bus of the ALU reservation station
// Signals:
//    in_write/in_op/in_lock1/in_data1/in_lock2/in_data2/in_dest  dispatch from decoder
//    stall                                                       station full
//    cdb_valid/cdb_tag/cdb_data                                  common data bus broadcast
//    alu_valid/alu_ready/alu_op/alu_a/alu_b/alu_dest             issue handshake to the ALU
// master = decoder/CDB/ALU side, slave = the reservation station.
interface alu_rs_scheduler_if #(
   parameter int OP_W   = 5,
   parameter int TAG_W  = 3,
   parameter int LOCK_W = 4,
   parameter int DATA_W = 32
);
   logic              in_write;
   logic [OP_W-1:0]   in_op;
   logic [LOCK_W-1:0] in_lock1;
   logic [DATA_W-1:0] in_data1;
   logic [LOCK_W-1:0] in_lock2;
   logic [DATA_W-1:0] in_data2;
   logic [TAG_W-1:0]  in_dest;
   logic              stall;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              alu_valid;
   logic              alu_ready;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [TAG_W-1:0]  alu_dest;
   modport master (
      output in_write, in_op, in_lock1, in_data1, in_lock2, in_data2, in_dest,
      output cdb_valid, cdb_tag, cdb_data, alu_ready,
      input  stall, alu_valid, alu_op, alu_a, alu_b, alu_dest
   );
   modport slave (
      input  in_write, in_op, in_lock1, in_data1, in_lock2, in_data2, in_dest,
      input  cdb_valid, cdb_tag, cdb_data, alu_ready,
      output stall, alu_valid, alu_op, alu_a, alu_b, alu_dest
   );
endinterface

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: reservation station holding ALU ops until operands resolve, issuing oldest-ready first
// Ports:
//    clk          rising-edge clock
//    rst          synchronous active-low reset
//    flush        mispredict flush, discards all contents
//    bus          alu_rs_scheduler_if.slave (dispatch, stall, CDB snoop, ALU issue handshake)
//    perf_issued  issued-op counter (only with ALU_RS_PERF_EN)
//    perf_stall   rejected-dispatch cycle counter (only with ALU_RS_PERF_EN)
// Optional feature macro: ALU_RS_PERF_EN.
module alu_rs_scheduler #(
   parameter int ENTRIES = 4,
   parameter int OP_W    = 5,
   parameter int TAG_W   = 3,
   parameter int LOCK_W  = 4,
   parameter int DATA_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
`ifdef ALU_RS_PERF_EN
   output logic [31:0]            perf_issued,
   output logic [31:0]            perf_stall,
`endif
   alu_rs_scheduler_if.slave      bus
);
   localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CW = $clog2(ENTRIES + 1);
   localparam int MSB = LOCK_W - 1;
   logic [ENTRIES-1:0] v_q, v_d, rdy;
   logic [OP_W-1:0]    op_q  [ENTRIES], op_d  [ENTRIES];
   logic [LOCK_W-1:0]  l1_q  [ENTRIES], l1_d  [ENTRIES];
   logic [LOCK_W-1:0]  l2_q  [ENTRIES], l2_d  [ENTRIES];
   logic [DATA_W-1:0]  d1_q  [ENTRIES], d1_d  [ENTRIES];
   logic [DATA_W-1:0]  d2_q  [ENTRIES], d2_d  [ENTRIES];
   logic [TAG_W-1:0]   dst_q [ENTRIES], dst_d [ENTRIES];
   // age = number of valid entries older than this one; kept dense so it never wraps
   logic [IW-1:0]      age_q [ENTRIES], age_d [ENTRIES];
   logic [CW-1:0]      count_q, count_d;
   logic               av_q, av_d;
   logic [OP_W-1:0]    aop_q, aop_d;
   logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
   logic [TAG_W-1:0]   adst_q, adst_d;
   logic [IW-1:0]      sel, fi;
   logic               found, load, wr, byp1, byp2;
   assign bus.stall     = count_q == CW'(ENTRIES);
   assign bus.alu_valid = av_q;
   assign bus.alu_op    = aop_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_dest  = adst_q;
   always_comb begin
      rdy   = v_q;
      sel   = '0;
      fi    = '0;
      found = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         rdy[i] = v_q[i] & l1_q[i][MSB] & l2_q[i][MSB];
         if (rdy[i] && (!found || age_q[i] < age_q[sel])) begin
            sel   = IW'(i);
            found = 1'b1;
         end
      end
      for (int i = ENTRIES - 1; i >= 0; i--) if (!v_q[i]) fi = IW'(i);
      load  = (!av_q || bus.alu_ready) && found;
      wr    = bus.in_write && !bus.stall;
      byp1  = bus.cdb_valid && !bus.in_lock1[MSB] && bus.in_lock1[TAG_W-1:0] == bus.cdb_tag;
      byp2  = bus.cdb_valid && !bus.in_lock2[MSB] && bus.in_lock2[TAG_W-1:0] == bus.cdb_tag;
      v_d   = v_q;
      op_d  = op_q;
      l1_d  = l1_q;
      l2_d  = l2_q;
      d1_d  = d1_q;
      d2_d  = d2_q;
      dst_d = dst_q;
      age_d = age_q;
      av_d   = av_q && !bus.alu_ready;
      aop_d  = aop_q;
      a_d    = a_q;
      b_d    = b_q;
      adst_d = adst_q;
      // slot is filled from pre-edge entry values; same-edge CDB data is not forwarded
      if (load) begin
         av_d   = 1'b1;
         aop_d  = op_q[sel];
         a_d    = d1_q[sel];
         b_d    = d2_q[sel];
         adst_d = dst_q[sel];
         v_d[sel] = 1'b0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
         if (v_q[i] && bus.cdb_valid && !l1_q[i][MSB] && l1_q[i][TAG_W-1:0] == bus.cdb_tag) begin
            l1_d[i][MSB] = 1'b1;
            d1_d[i]      = bus.cdb_data;
         end
         if (v_q[i] && bus.cdb_valid && !l2_q[i][MSB] && l2_q[i][TAG_W-1:0] == bus.cdb_tag) begin
            l2_d[i][MSB] = 1'b1;
            d2_d[i]      = bus.cdb_data;
         end
         if (load && v_q[i] && age_q[i] > age_q[sel]) age_d[i] = age_q[i] - 1'b1;
      end
      // fi is a free slot, so it can never be the entry being issued this edge
      if (wr) begin
         v_d[fi]   = 1'b1;
         op_d[fi]  = bus.in_op;
         l1_d[fi]  = byp1 ? {1'b1, bus.in_lock1[TAG_W-1:0]} : bus.in_lock1;
         d1_d[fi]  = byp1 ? bus.cdb_data : bus.in_data1;
         l2_d[fi]  = byp2 ? {1'b1, bus.in_lock2[TAG_W-1:0]} : bus.in_lock2;
         d2_d[fi]  = byp2 ? bus.cdb_data : bus.in_data2;
         dst_d[fi] = bus.in_dest;
         age_d[fi] = IW'(count_q - CW'(load));
      end
      count_d = count_q + CW'(wr) - CW'(load);
   end
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         v_q     <= '0;
         count_q <= '0;
         av_q    <= 1'b0;
         aop_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         adst_q  <= '0;
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         av_q    <= av_d;
         aop_q   <= aop_d;
         a_q     <= a_d;
         b_q     <= b_d;
         adst_q  <= adst_d;
      end
   end
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      dst_q <= dst_d;
      age_q <= age_d;
   end
`ifdef ALU_RS_PERF_EN
   logic [31:0] perf_issued_q, perf_stall_q;
   assign perf_issued = perf_issued_q;
   assign perf_stall  = perf_stall_q;
   // counters survive flush; only reset clears them
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_issued_q <= perf_issued_q + 32'(av_q && bus.alu_ready);
         perf_stall_q  <= perf_stall_q + 32'(bus.in_write && bus.stall);
      end
   end
`endif
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: randomized scoreboard bench for alu_rs_scheduler against a queue-based reference model
module tb_alu_rs_scheduler;
   localparam int ENTRIES = 4, OP_W = 5, TAG_W = 3, LOCK_W = 4, DATA_W = 32;
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
   always #5 clk = ~clk;
   alu_rs_scheduler_if #(.OP_W(OP_W), .TAG_W(TAG_W), .LOCK_W(LOCK_W), .DATA_W(DATA_W)) bus ();
`ifdef ALU_RS_PERF_EN
   logic [31:0] perf_issued, perf_stall, m_iss, m_stl;
`endif
   alu_rs_scheduler #(.ENTRIES(ENTRIES), .OP_W(OP_W), .TAG_W(TAG_W), .LOCK_W(LOCK_W), .DATA_W(DATA_W)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
`ifdef ALU_RS_PERF_EN
      .perf_issued(perf_issued),
      .perf_stall(perf_stall),
`endif
      .bus(bus)
   );
   typedef struct {
      logic [OP_W-1:0]   op;
      bit                r1, r2;
      logic [TAG_W-1:0]  t1, t2;
      logic [DATA_W-1:0] d1, d2;
      logic [TAG_W-1:0]  dest;
   } ent_t;
   typedef struct {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a, b;
      logic [TAG_W-1:0]  dest;
   } iss_t;
   ent_t rs[$];
   iss_t exp_q[$];
   bit   slot_v = 1'b0;
   int   errors = 0, checks = 0;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask
   // reference: rs[] is held in dispatch order, so the first ready element is the oldest ready one
   always @(posedge clk) begin
      bit   full;
      ent_t e;
      full = rs.size() == ENTRIES;
`ifdef ALU_RS_PERF_EN
      if (!rst) begin
         m_iss = '0;
         m_stl = '0;
      end else begin
         if (slot_v && bus.alu_ready) m_iss++;
         if (bus.in_write && full) m_stl++;
      end
`endif
      if (!rst || flush) begin
         rs.delete();
         exp_q.delete();
         slot_v = 1'b0;
      end else begin
         if (!slot_v || bus.alu_ready) begin
            slot_v = 1'b0;
            for (int i = 0; i < rs.size(); i++) begin
               if (rs[i].r1 && rs[i].r2) begin
                  exp_q.push_back('{rs[i].op, rs[i].d1, rs[i].d2, rs[i].dest});
                  rs.delete(i);
                  slot_v = 1'b1;
                  break;
               end
            end
         end
         if (bus.cdb_valid) begin
            foreach (rs[i]) begin
               if (!rs[i].r1 && rs[i].t1 == bus.cdb_tag) begin rs[i].r1 = 1'b1; rs[i].d1 = bus.cdb_data; end
               if (!rs[i].r2 && rs[i].t2 == bus.cdb_tag) begin rs[i].r2 = 1'b1; rs[i].d2 = bus.cdb_data; end
            end
         end
         if (bus.in_write && !full) begin
            e.op   = bus.in_op;
            e.r1   = bus.in_lock1[LOCK_W-1];
            e.t1   = bus.in_lock1[TAG_W-1:0];
            e.d1   = bus.in_data1;
            e.r2   = bus.in_lock2[LOCK_W-1];
            e.t2   = bus.in_lock2[TAG_W-1:0];
            e.d2   = bus.in_data2;
            e.dest = bus.in_dest;
            if (!e.r1 && bus.cdb_valid && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.d1 = bus.cdb_data; end
            if (!e.r2 && bus.cdb_valid && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.d2 = bus.cdb_data; end
            rs.push_back(e);
         end
      end
   end
   // monitor: compares status every cycle and pops the scoreboard on each handshake
   always @(negedge clk) begin
      iss_t x;
      chk("stall", 64'(bus.stall), 64'(rs.size() == ENTRIES));
      chk("alu_valid", 64'(bus.alu_valid), 64'(slot_v));
`ifdef ALU_RS_PERF_EN
      chk("perf_issued", 64'(perf_issued), 64'(m_iss));
      chk("perf_stall", 64'(perf_stall), 64'(m_stl));
`endif
      if (bus.alu_valid && bus.alu_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got dest %0h expected no issue at %0t", bus.alu_dest, $time);
         end else begin
            x = exp_q.pop_front();
            chk("alu_op", 64'(bus.alu_op), 64'(x.op));
            chk("alu_a", 64'(bus.alu_a), 64'(x.a));
            chk("alu_b", 64'(bus.alu_b), 64'(x.b));
            chk("alu_dest", 64'(bus.alu_dest), 64'(x.dest));
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.in_write = 1'b0;
      bus.cdb_valid = 1'b0;
   endtask
   task automatic set_in(input logic [OP_W-1:0] op, input logic [LOCK_W-1:0] l1, input logic [DATA_W-1:0] d1,
                         input logic [LOCK_W-1:0] l2, input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] dest);
      bus.in_write = 1'b1;
      bus.in_op    = op;
      bus.in_lock1 = l1;
      bus.in_data1 = d1;
      bus.in_lock2 = l2;
      bus.in_data2 = d2;
      bus.in_dest  = dest;
   endtask
   task automatic dispatch(input logic [OP_W-1:0] op, input logic [LOCK_W-1:0] l1, input logic [DATA_W-1:0] d1,
                           input logic [LOCK_W-1:0] l2, input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] dest);
      set_in(op, l1, d1, l2, d2, dest);
      tick();
      bus.in_write = 1'b0;
   endtask
   task automatic bcast(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = tag;
      bus.cdb_data  = data;
      tick();
      bus.cdb_valid = 1'b0;
   endtask
   task automatic chk_zero();
      @(negedge clk);
      chk("rst_valid", 64'(bus.alu_valid), 64'd0);
      chk("rst_op", 64'(bus.alu_op), 64'd0);
      chk("rst_a", 64'(bus.alu_a), 64'd0);
      chk("rst_b", 64'(bus.alu_b), 64'd0);
      chk("rst_dest", 64'(bus.alu_dest), 64'd0);
      chk("rst_stall", 64'(bus.stall), 64'd0);
   endtask
   initial begin
      idle();
      set_in('0, '0, '0, '0, '0, '0);
      bus.in_write  = 1'b0;
      bus.cdb_tag   = '0;
      bus.cdb_data  = '0;
      bus.alu_ready = 1'b1;
      repeat (2) tick();
      chk_zero();
      rst = 1'b1;
      tick();
      dispatch(5'd1, 4'b1000, 32'd5, 4'b1000, 32'd7, 3'd2);
      repeat (3) tick();
      dispatch(5'd2, 4'b0011, 32'd0, 4'b1000, 32'd9, 3'd4);
      repeat (2) tick();
      bcast(3'd3, 32'h10);
      repeat (3) tick();
      bus.alu_ready = 1'b0;
      dispatch(5'd3, 4'b0101, 32'd0, 4'b1000, 32'd1, 3'd1);
      dispatch(5'd3, 4'b1000, 32'd2, 4'b1000, 32'd3, 3'd2);
      dispatch(5'd3, 4'b1000, 32'd4, 4'b1000, 32'd5, 3'd3);
      repeat (3) tick();
      bcast(3'd5, 32'h55);
      bus.alu_ready = 1'b1;
      repeat (5) tick();
      for (int i = 0; i < 5; i++) dispatch(5'(i + 4), 4'b0110, 32'd0, 4'b1000, 32'(i), 3'(i));
      tick();
      bcast(3'd6, 32'h66);
      repeat (6) tick();
      set_in(5'd9, 4'b0100, 32'd0, 4'b1000, 32'd1, 3'd7);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 3'd4;
      bus.cdb_data  = 32'hAB;
      tick();
      idle();
      repeat (3) tick();
      bus.alu_ready = 1'b0;
      for (int i = 0; i < 3; i++) dispatch(5'd10, 4'b1000, 32'(i), 4'b0001, 32'd0, 3'(i));
      dispatch(5'd11, 4'b1000, 32'd1, 4'b1000, 32'd2, 3'd5);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.alu_ready = 1'b1;
      @(negedge clk);
      chk("flush_valid", 64'(bus.alu_valid), 64'd0);
      chk("flush_stall", 64'(bus.stall), 64'd0);
      for (int c = 0; c < 3000; c++) begin
         bus.in_write  = $urandom_range(0, 2) != 0;
         bus.in_op     = 5'($urandom);
         bus.in_lock1  = {1'($urandom_range(0, 1)), 3'($urandom)};
         bus.in_data1  = $urandom;
         bus.in_lock2  = {1'($urandom_range(0, 1)), 3'($urandom)};
         bus.in_data2  = $urandom;
         bus.in_dest   = 3'($urandom);
         bus.cdb_valid = $urandom_range(0, 4) < 2;
         bus.cdb_tag   = 3'($urandom);
         bus.cdb_data  = $urandom;
         bus.alu_ready = $urandom_range(0, 9) < 7;
         flush         = $urandom_range(0, 99) == 0;
         rst           = $urandom_range(0, 299) != 0;
         tick();
      end
      idle();
      flush = 1'b0;
      rst   = 1'b1;
      bus.alu_ready = 1'b1;
      for (int t = 0; t < 8; t++) bcast(3'(t), 32'(t + 100));
      repeat (6) tick();
      chk("drained", 64'(exp_q.size()), 64'd0);
      dispatch(5'd12, 4'b0010, 32'd0, 4'b1000, 32'd3, 3'd1);
      dispatch(5'd13, 4'b1000, 32'd3, 4'b1000, 32'd3, 3'd2);
      rst = 1'b0;
      tick();
      chk_zero();
      rst = 1'b1;
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the shared integer ALU.
- Accepts decoded ALU operations from the decoder stage (fields of the ALU bus) and holds them until both operands are resolved. Operands resolve either at dispatch or by snooping the common data bus (CDB).
- Issues the oldest ready entry to the single ALU through a valid/ready handshake, and back-pressures the decoder with `stall` when full.

Parameters:
- ENTRIES, 4, station depth (2..8).
- OP_W, 5, width of the simplified opcode.
- TAG_W, 3, ROB entry index width.
- LOCK_W, 4, register lock width (= TAG_W+1). MSB=1 means "no lock"; low TAG_W bits are the ROB tag.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  mispredict flush; discards all contents.
- in_write  in  1  decoder dispatch strobe.
- in_op  in  OP_W  operation.
- in_lock1  in  LOCK_W  operand A lock.
- in_data1  in  DATA_W  operand A value (valid when unlocked).
- in_lock2  in  LOCK_W  operand B lock.
- in_data2  in  DATA_W  operand B value.
- in_dest  in  TAG_W  destination ROB tag.
- stall  out  1  station full; dispatch not accepted.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  broadcast ROB tag.
- cdb_data  in  DATA_W  broadcast value.
- alu_valid  out  1  issue slot holds an operation.
- alu_ready  in  1  ALU accepts this cycle.
- alu_op  out  OP_W  issued operation.
- alu_a  out  DATA_W  issued operand A.
- alu_b  out  DATA_W  issued operand B.
- alu_dest  out  TAG_W  issued destination tag.

Behaviour:
- **Reset** (rst==0 at edge): all entries invalid, count=0, alu_valid=0, alu_op/alu_a/alu_b/alu_dest=0. Reset mid-operation discards everything; no partial issue.
- **Flush** (rst==1, flush==1): same clearing as reset. Overrides in_write, CDB capture and issue that cycle.
- **Per-entry state**: valid, op, lock1/data1, lock2/data2, dest, age. Ready = valid && lock1[MSB] && lock2[MSB].
- **stall**: combinational, = (count == ENTRIES). It uses the count before any same-cycle issue, so a write arriving on a cycle where an entry frees while full is rejected. The decoder must hold and retry.
- **Dispatch**: on in_write && !stall, write the lowest-index free entry; its age becomes youngest.
- **CDB snoop, stored entries**: on cdb_valid, every valid entry whose locked operand tag == cdb_tag loads cdb_data and sets its lock MSB, at that same edge.
- **CDB snoop, dispatching entry**: the same match is also applied to in_lock1/in_lock2 on the dispatch cycle (allocation bypass), so a broadcast is never missed. Both operands may capture from one broadcast.
- **Issue slot**: a single output register.
  - Load when (!alu_valid || alu_ready), at least one entry is ready, and no flush.
  - Selection = oldest ready entry by age; the selected entry is freed that edge.
  - Values loaded into the slot must already be resolved before that edge; CDB data from the same edge is not forwarded into the slot.
  - Freed entry and new dispatch in the same cycle are both legal; dispatch may reuse another free index but not the one being freed.
- **Handshake**: alu_valid stays high and outputs stay stable until alu_valid && alu_ready; back-to-back issue is possible every cycle.
- **Latency**: entry dispatched with both operands unlocked at edge E gives alu_valid=1 after edge E+1 (issue slot empty or draining).
- **Age**: strict dispatch order (age matrix or saturating per-entry counters); no two valid entries share an age. Ordering survives frees (no wrap error).
- **count**: +1 on accepted dispatch, −1 on issue-slot load, net 0 on both in the same cycle.
- **Never**: issue an entry with a set lock; lose or duplicate an entry.

Optional Feature:
- Macro: ALU_RS_PERF_EN.
- Defined:
  - Adds outputs perf_issued [31:0] (increments on each alu_valid&&alu_ready) and perf_stall [31:0] (increments each cycle in_write&&stall).
  - Both are cleared by reset only, not flush, and wrap modulo 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- **Ready dispatch**: release reset; write op=ADD, lock1=lock2=4'b1000, data 5 and 7, dest=2; alu_ready=1 -> alu_valid high one cycle after write edge with alu_a=5, alu_b=7, alu_dest=2; then empty.
- **CDB wakeup**: write lock1=4'b0011 (tag 3), lock2 unlocked, data2=9 -> no issue. Broadcast cdb_tag=3, cdb_data=0x10 -> issue next cycle with alu_a=0x10, alu_b=9.
- **Oldest-first and back-pressure**:
  - Dispatch A(dest1, waits tag5), B(dest2, ready), C(dest3, ready); hold alu_ready=0 -> alu_valid with dest2, held stable.
  - Broadcast tag5, then alu_ready=1 -> issue order 2, 1, 3.
- **Full/stall**:
  - Fill 4 entries blocked on tag 6 -> stall=1; a 5th write is ignored.
  - Broadcast tag 6 -> four issues in dispatch order; stall drops only after the first issue edge.
- **Bypass at allocation**: dispatch lock1=tag4 on the same cycle as cdb_valid, tag 4, data 0xAB -> entry issues with alu_a=0xAB.
- **Flush and reset**:
  - Flush with 3 entries plus a pending issue slot -> alu_valid=0, stall=0 next cycle.
  - Drive rst=0 mid-stream -> all outputs 0.
  - With ALU_RS_PERF_EN: perf counters survive flush and clear on reset.
